axis_tuple_arb: RTL
===================

AXIS_TUPLE_ARB -- requirements
Module: axis_tuple_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 256, giving the AXIS data width.
REQ-002 The block SHALL have parameter KEEP_W, default 32 (DATA_W/8), giving the byte-keep width.
REQ-003 The block SHALL have parameter TUSER_W, default 128, giving the tuple (tuser) width.
REQ-004 The block SHALL have port arb_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port arb_arst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 For each input n in {0,1}, the block SHALL have these slave ports:
- sn_tvalid, input, 1 bit.
- sn_tready, output, 1 bit.
- sn_tdata, input, DATA_W bits.
- sn_tkeep, input, KEEP_W bits.
- sn_tlast, input, 1 bit.
- sn_tuser, input, TUSER_W bits.
REQ-007 The block SHALL have these master ports:
- m_tvalid, output, 1 bit.
- m_tready, input, 1 bit.
- m_tdata, output, DATA_W bits.
- m_tkeep, output, KEEP_W bits.
- m_tlast, output, 1 bit.
- m_tuser, output, TUSER_W bits.
REQ-008 The block SHALL have ports pkt_cnt0 and pkt_cnt1, each output, 32 bits: completed-packet counts per input.
REQ-009 The block SHALL have port dbg_state, output, 2 bits: the current FSM state.

Function
REQ-010 The block SHALL share one downstream AXIS port between two tuple-carrying AXIS sources (tuser-merged streams) with packet-level round-robin arbitration.
REQ-011 The FSM SHALL have exactly three states: IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10; the encoding 2'b11 SHALL return to IDLE on the next edge.
REQ-012 In IDLE, the block SHALL drive s0_tready=0, s1_tready=0 and m_tvalid=0.
REQ-013 In IDLE with only sn_tvalid=1, the next state SHALL be GRANTn.
REQ-014 In IDLE with both tvalid=1, the next state SHALL be GRANT of the input not equal to last_grant.
REQ-015 In IDLE with neither tvalid=1, the state SHALL remain IDLE.
REQ-016 In GRANTn, m_tvalid/m_tdata/m_tkeep/m_tlast/m_tuser SHALL combinationally equal the sn_* inputs, with sn_tready=m_tready and the other input's tready=0 (zero-latency passthrough).
REQ-017 A beat SHALL transfer only when m_tvalid=1 and m_tready=1.
REQ-018 In GRANTn, a transfer with sn_tlast=1 SHALL move the FSM to IDLE, set last_grant<=n, and increment pkt_cnt_n.
REQ-019 The grant SHALL be held for the whole packet; the other input's tvalid SHALL NOT preempt it.
REQ-020 Arbitration latency SHALL be one cycle from tvalid observed in IDLE to the first possible transfer, giving exactly one idle cycle between consecutive packets.
REQ-021 Outside GRANT states, m_tdata, m_tkeep and m_tuser SHALL be 0 and m_tlast SHALL be 0.
REQ-022 pkt_cnt0 and pkt_cnt1 SHALL wrap from 32'hFFFF_FFFF to 0 with no saturation or flag.
REQ-023 A single-beat packet (tlast on the first beat) SHALL complete in one GRANT cycle.
REQ-024 When m_tready=0, the block SHALL hold state and the transfer SHALL stall; the master outputs SHALL remain equal to the granted source's stable AXIS signals.
REQ-025 tuser SHALL be forwarded on every beat unmodified; the block SHALL NOT inspect tuser or tdata.

Reset
REQ-026 arb_arst=0 SHALL immediately force the following, independent of arb_aclk:
- state=IDLE.
- last_grant=1, so input 0 wins the first tie.
- pkt_cnt0=0 and pkt_cnt1=0.
- All tready=0, m_tvalid=0, and all m_* data outputs 0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet with no tlast emitted; after release, arbitration SHALL restart from IDLE.
REQ-028 Reset deassertion SHALL be synchronized internally (two-flop) before the FSM leaves IDLE.

Structure
REQ-029 The state encodings and the widths DATA_W, KEEP_W and TUSER_W SHALL reside in the shared package used by the tuser_in/tuser_out FSMs.
REQ-030 The next-grant decision SHALL be a sub-module rr_pick2, taking two request bits and last_grant and returning the winner index; the FSM, mux and counters SHALL reside in the top level.

Verification
REQ-031 Reset release, then s0 sends a 3-beat packet with tuser=128'hA5 and m_tready=1 -> the FSM enters GRANT0 one cycle later, 3 beats leave with tuser=128'hA5 on each, and pkt_cnt0=1.
REQ-032 s0 and s1 both valid continuously, 2-beat packets -> output packet order is 0,1,0,1, with exactly one idle cycle between packets.
REQ-033 In GRANT1, toggle m_tready 1/0 on each beat of a 4-beat packet -> no beat is lost or duplicated, s0_tready=0 throughout, and s1_tready tracks m_tready.
REQ-034 Assert arb_arst=0 during beat 2 of a 4-beat packet -> outputs go to 0 immediately, pkt_cnt=0, and after release a new s0 packet is granted first.
REQ-035 Preload pkt_cnt1=32'hFFFF_FFFF via force, then send one s1 packet -> pkt_cnt1=0.
REQ-036 Single-beat packets on s1 only, back to back -> each completes in one GRANT cycle with the pattern IDLE,GRANT1 repeating, and s0 is never granted.

Source files
------------

// File: rtl/axis_tuple_arb_pkg.sv
// Shared definitions for the two-input AXIS tuple arbiter: default widths and FSM encoding.
package axis_tuple_arb_pkg;

  localparam int unsigned DefDataW  = 256;
  localparam int unsigned DefKeepW  = DefDataW / 8;
  localparam int unsigned DefTuserW = 128;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrant0 = 2'b01,
    StGrant1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/axis_tuple_arb_if.sv
// AXI-Stream link carrying a tuser tuple alongside data and keep.
interface axis_tuple_arb_if
  import axis_tuple_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned KEEP_W  = DefKeepW,
  parameter int unsigned TUSER_W = DefTuserW
) ();

  logic               tvalid;
  logic               tready;
  logic [DATA_W-1:0]  tdata;
  logic [KEEP_W-1:0]  tkeep;
  logic               tlast;
  logic [TUSER_W-1:0] tuser;

  modport master (
    output tvalid, tdata, tkeep, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tuser,
    output tready
  );

endinterface

// File: rtl/axis_tuple_arb_rr_pick2.sv
// Two-way round-robin pick: on a tie the input that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       winner_o
);

  always_comb begin
    winner_o = 1'b0;
    if (&req_i) begin
      winner_o = ~last_grant_i;
    end else begin
      // No request also yields 1; the caller only looks when something is requesting.
      winner_o = ~req_i[0];
    end
  end

endmodule

// File: rtl/axis_tuple_arb.sv
// Packet-level round-robin arbiter merging two tuple-carrying AXIS sources onto one master port.
module axis_tuple_arb
  import axis_tuple_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned KEEP_W  = DefKeepW,
  parameter int unsigned TUSER_W = DefTuserW
) (
  input  logic                    arb_aclk,
  input  logic                    arb_arst,
  axis_tuple_arb_if.slave         s0,
  axis_tuple_arb_if.slave         s1,
  axis_tuple_arb_if.master        m,
  output logic [31:0]             pkt_cnt0,
  output logic [31:0]             pkt_cnt1,
  output logic [1:0]              dbg_state
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [31:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        pick;
  logic        run_ok;

  // Assertion is immediate via the async clear; release only takes effect two edges later.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run_ok     = rst_sync_q[1];

  rr_pick2 u_pick (
    .req_i       ({s1.tvalid, s0.tvalid}),
    .last_grant_i(last_grant_q),
    .winner_o    (pick)
  );

  always_ff @(posedge arb_aclk or negedge arb_arst) begin
    if (!arb_arst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      rst_sync_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      rst_sync_q   <= rst_sync_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    case (state_q)
      StIdle: begin
        if (run_ok && (s0.tvalid || s1.tvalid)) begin
          state_d = pick ? StGrant1 : StGrant0;
        end
      end
      StGrant0: begin
        if (s0.tvalid && m.tready && s0.tlast) begin
          state_d      = StIdle;
          last_grant_d = 1'b0;
          pkt_cnt0_d   = pkt_cnt0_q + 32'd1;
        end
      end
      StGrant1: begin
        if (s1.tvalid && m.tready && s1.tlast) begin
          state_d      = StIdle;
          last_grant_d = 1'b1;
          pkt_cnt1_d   = pkt_cnt1_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s0.tready = 1'b0;
    s1.tready = 1'b0;
    m.tvalid  = 1'b0;
    m.tdata   = {DATA_W{1'b0}};
    m.tkeep   = {KEEP_W{1'b0}};
    m.tlast   = 1'b0;
    m.tuser   = {TUSER_W{1'b0}};
    case (state_q)
      StGrant0: begin
        m.tvalid  = s0.tvalid;
        m.tdata   = s0.tdata;
        m.tkeep   = s0.tkeep;
        m.tlast   = s0.tlast;
        m.tuser   = s0.tuser;
        s0.tready = m.tready;
      end
      StGrant1: begin
        m.tvalid  = s1.tvalid;
        m.tdata   = s1.tdata;
        m.tkeep   = s1.tkeep;
        m.tlast   = s1.tlast;
        m.tuser   = s1.tuser;
        s1.tready = m.tready;
      end
      default: ;
    endcase
  end

  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;
  assign dbg_state = state_q;

endmodule
